// File: rtl/fpu_add_param.sv
// fpu_add_param: multi-cycle IEEE-754-style adder/subtractor with flush-to-zero,
// iterative normalization (NORM_STEP bits per cycle) and RNE/truncate rounding.
module fpu_add_param #(
   parameter int EXP_W     = 8,
   parameter int MAN_W     = 23,
   parameter int NORM_STEP = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   opa,
   input  logic [EXP_W+MAN_W:0]   opb,
   input  logic                   is_addition,
   input  logic                   round_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags,
   output logic                   busy
);
   localparam int W = EXP_W + MAN_W + 1;
   localparam int D = MAN_W + 5;
   localparam int E = EXP_W + 1;
   localparam logic [E-1:0] EMAX = {1'b0, {EXP_W{1'b1}}};

   typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, HOLD} state_t;
   state_t state, next_state;
   logic accept;

   logic [W-1:0] a_q, b_q;
   logic         add_q, rm_q, sign_q;
   logic [D-1:0] sig_q;
   logic [E-1:0] exp_q;

   logic             sa, sb, sbe, eff_add, za, zb, swap;
   logic             nan_a, nan_b, inf_a, inf_b, special, al_sign;
   logic [EXP_W-1:0] ea, eb, big_e, diff;
   logic [D-1:0]     sig_a, sig_b, big_sig, small_sig, small_sh, sum, al_sig;
   logic [2*D-1:0]   ext;
   logic [E-1:0]     al_exp;
   logic [W-1:0]     sp_res;
   logic [3:0]       sp_flags;
   int               sh;

   always_comb begin
      sa        = a_q[W-1];
      sb        = b_q[W-1];
      sbe       = sb ^ ~add_q;
      eff_add   = sa ^ sb ^ add_q;
      ea        = a_q[W-2:MAN_W];
      eb        = b_q[W-2:MAN_W];
      za        = ea == '0;
      zb        = eb == '0;
      sig_a     = za ? '0 : {2'b01, a_q[MAN_W-1:0], 3'b000};
      sig_b     = zb ? '0 : {2'b01, b_q[MAN_W-1:0], 3'b000};
      swap      = (zb ? '0 : b_q[W-2:0]) > (za ? '0 : a_q[W-2:0]);
      big_e     = swap ? eb : ea;
      diff      = big_e - (swap ? ea : eb);
      big_sig   = swap ? sig_b : sig_a;
      small_sig = swap ? sig_a : sig_b;
      sh        = int'(diff) > D ? D : int'(diff);
      // lower half of ext collects every bit shifted past the datapath
      ext       = {small_sig, {D{1'b0}}} >> sh;
      small_sh  = ext[2*D-1:D] | {{(D-1){1'b0}}, |ext[D-1:0]};
      sum       = eff_add ? big_sig + small_sh : big_sig - small_sh;
      al_sig    = sum[D-1] ? {1'b0, sum[D-1:2], |sum[1:0]} : sum;
      al_exp    = {1'b0, big_e} + {{EXP_W{1'b0}}, sum[D-1]};
      al_sign   = (!eff_add && sum == '0) ? 1'b0 : (swap ? sbe : sa);
      nan_a     = &ea && |a_q[MAN_W-1:0];
      nan_b     = &eb && |b_q[MAN_W-1:0];
      inf_a     = &ea && ~|a_q[MAN_W-1:0];
      inf_b     = &eb && ~|b_q[MAN_W-1:0];
      special   = &ea | &eb;
      sp_flags  = {nan_a | nan_b | (inf_a & inf_b & ~eff_add), 3'b000};
      sp_res    = sp_flags[3] ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}}
                              : {inf_a ? sa : sbe, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   end

   int   lz, s1, em1, shamt;
   logic found, done;

   always_comb begin
      lz    = 0;
      found = 1'b0;
      for (int i = D - 2; i >= 0; i--) begin
         found = found | sig_q[i];
         lz    = found ? lz : lz + 1;
      end
      em1   = int'(exp_q) - 1;
      s1    = lz < NORM_STEP ? lz : NORM_STEP;
      shamt = s1 < em1 ? s1 : em1;
      done  = sig_q[D-2] | (sig_q == '0) | (exp_q <= E'(1));
   end

   logic             g, r, s, inc, rc, hid;
   logic [MAN_W+1:0] rnd;
   logic [MAN_W-1:0] fr;
   logic [E-1:0]     ex;
   logic [W-1:0]     rd_res;
   logic [3:0]       rd_flags;

   always_comb begin
      g        = sig_q[2];
      r        = sig_q[1];
      s        = sig_q[0];
      inc      = ~rm_q & g & (r | s | sig_q[3]);
      rnd      = {1'b0, sig_q[D-2:3]} + {{(MAN_W+1){1'b0}}, inc};
      rc       = rnd[MAN_W+1];
      hid      = rc | rnd[MAN_W];
      fr       = rc ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
      ex       = exp_q + {{EXP_W{1'b0}}, rc};
      // a nonzero result left without its hidden bit would be subnormal: flush it
      rd_res   = (sig_q == '0 || !hid) ? {sign_q, {(W-1){1'b0}}}
               : (ex >= EMAX) ? (rm_q ? {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}}
                                      : {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}})
               : {sign_q, ex[EXP_W-1:0], fr};
      rd_flags = (sig_q == '0) ? 4'b0000 : !hid ? 4'b0011
               : (ex >= EMAX) ? 4'b0101 : {3'b000, g | r | s};
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= next_state;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = accept ? ALIGN : IDLE;
         ALIGN:   next_state = special ? HOLD : NORM;
         NORM:    next_state = done ? ROUND : NORM;
         ROUND:   next_state = HOLD;
         HOLD:    next_state = out_ready ? (accept ? ALIGN : IDLE) : HOLD;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rst && (state == IDLE || (state == HOLD && out_ready));
      accept    = in_valid & in_ready;
      out_valid = state == HOLD;
      busy      = state != IDLE;
   end

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         add_q  <= 1'b0;
         rm_q   <= 1'b0;
         sign_q <= 1'b0;
         sig_q  <= '0;
         exp_q  <= '0;
         result <= '0;
         flags  <= '0;
      end else begin
         if (accept) begin
            a_q   <= opa;
            b_q   <= opb;
            add_q <= is_addition;
            rm_q  <= round_mode;
         end
         if (state == ALIGN) begin
            sig_q  <= al_sig;
            exp_q  <= al_exp;
            sign_q <= al_sign;
         end
         if (state == ALIGN && special) begin
            result <= sp_res;
            flags  <= sp_flags;
         end
         if (state == NORM && !done) begin
            sig_q <= sig_q << shamt;
            exp_q <= exp_q - E'(shamt);
         end
         if (state == ROUND) begin
            result <= rd_res;
            flags  <= rd_flags;
         end
      end
endmodule

// File: tb/tb_fpu_add_param.sv
// tb_fpu_add_param: directed scoreboard checks of fpu_add_param in its binary32
// configuration, including latency, hold/back-to-back handshake and reset abort.
module tb_fpu_add_param;
   logic        clk = 1'b0, rst = 1'b0, in_valid = 1'b0, is_addition = 1'b1;
   logic        round_mode = 1'b0, out_ready = 1'b0;
   logic [31:0] opa = '0, opb = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] result;
   logic [3:0]  flags;
   int          n_chk = 0, n_fail = 0;

   typedef struct {logic [31:0] res; logic [3:0] fl; int lat;} exp_t;
   typedef struct {logic [31:0] a, b; logic add, rm; logic [31:0] res; logic [3:0] fl; int lat;} vec_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   fpu_add_param dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opa(opa), .opb(opb), .is_addition(is_addition), .round_mode(round_mode),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .flags(flags), .busy(busy)
   );

   task automatic send(input logic [31:0] a, b, input logic add, rm,
                       input logic [31:0] res, input logic [3:0] fl, input int lat,
                       output logic acc);
      opa = a; opb = b; is_addition = add; round_mode = rm; in_valid = 1'b1;
      sb.push_back('{res, fl, lat});
      #1 acc = in_ready;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int cyc, output logic to);
      cyc = 1;
      while (!out_valid && cyc < 64) begin
         @(posedge clk);
         #1 cyc++;
      end
      to = !out_valid;
   endtask

   task automatic drain;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset;
      in_valid = 1'b1;
      opa = 32'h3F800000; opb = 32'h3F800000;
      #12;
      n_chk++;
      if ({out_valid, busy, in_ready, result, flags} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: ov=%b busy=%b ir=%b res=%h fl=%b, expected all zero",
                  out_valid, busy, in_ready, result, flags);
      end
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ir=%b busy=%b, expected 1 0", in_ready, busy);
      end
   endtask

   task automatic run_table(input string name, input vec_t v[$]);
   endtask

   task automatic test_add;
      vec_t v[$];
      exp_t e; int cyc; logic to, acc;
      v.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 4'b0000, 4});
      v.push_back('{32'h3FFFFFFF, 32'h33800000, 1'b1, 1'b0, 32'h40000000, 4'b0001, 4});
      v.push_back('{32'h00000001, 32'h3F800000, 1'b1, 1'b0, 32'h3F800000, 4'b0000, 4});
      v.push_back('{32'hBF800000, 32'hC0000000, 1'b1, 1'b0, 32'hC0400000, 4'b0000, 4});
      foreach (v[i]) begin
         send(v[i].a, v[i].b, v[i].add, v[i].rm, v[i].res, v[i].fl, v[i].lat, acc);
         wait_out(cyc, to);
         e = sb.pop_front();
         n_chk++;
         if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL add[%0d]: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                     i, result, flags, cyc, to, e.res, e.fl, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_cancel;
      vec_t v[$];
      exp_t e; int cyc; logic to, acc;
      v.push_back('{32'h3F800000, 32'h3F7FFFFF, 1'b0, 1'b0, 32'h33800000, 4'b0000, 10});
      v.push_back('{32'h3FC00000, 32'h3F800000, 1'b0, 1'b0, 32'h3F000000, 4'b0000, 5});
      v.push_back('{32'h40400000, 32'hBF800000, 1'b1, 1'b0, 32'h40000000, 4'b0000, 4});
      v.push_back('{32'h3F800000, 32'h3F800000, 1'b0, 1'b1, 32'h00000000, 4'b0000, 4});
      v.push_back('{32'hBF800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 4'b0000, 4});
      v.push_back('{32'h80000000, 32'h80000000, 1'b1, 1'b0, 32'h80000000, 4'b0000, 4});
      v.push_back('{32'h00800001, 32'h00800000, 1'b0, 1'b0, 32'h00000000, 4'b0011, 4});
      foreach (v[i]) begin
         send(v[i].a, v[i].b, v[i].add, v[i].rm, v[i].res, v[i].fl, v[i].lat, acc);
         wait_out(cyc, to);
         e = sb.pop_front();
         n_chk++;
         if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL cancel[%0d]: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                     i, result, flags, cyc, to, e.res, e.fl, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_round;
      vec_t v[$];
      exp_t e; int cyc; logic to, acc;
      v.push_back('{32'h3F800000, 32'h33800000, 1'b1, 1'b0, 32'h3F800000, 4'b0001, 4});
      v.push_back('{32'h3F800000, 32'h33C00000, 1'b1, 1'b0, 32'h3F800001, 4'b0001, 4});
      v.push_back('{32'h3F800000, 32'h33800000, 1'b1, 1'b1, 32'h3F800000, 4'b0001, 4});
      v.push_back('{32'h3F800000, 32'h33C00000, 1'b1, 1'b1, 32'h3F800000, 4'b0001, 4});
      foreach (v[i]) begin
         send(v[i].a, v[i].b, v[i].add, v[i].rm, v[i].res, v[i].fl, v[i].lat, acc);
         wait_out(cyc, to);
         e = sb.pop_front();
         n_chk++;
         if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL round[%0d]: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                     i, result, flags, cyc, to, e.res, e.fl, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_overflow;
      vec_t v[$];
      exp_t e; int cyc; logic to, acc;
      v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0, 32'h7F800000, 4'b0101, 4});
      v.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b1, 32'h7F7FFFFF, 4'b0101, 4});
      v.push_back('{32'hFF7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'hFF7FFFFF, 4'b0101, 4});
      foreach (v[i]) begin
         send(v[i].a, v[i].b, v[i].add, v[i].rm, v[i].res, v[i].fl, v[i].lat, acc);
         wait_out(cyc, to);
         e = sb.pop_front();
         n_chk++;
         if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL overflow[%0d]: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                     i, result, flags, cyc, to, e.res, e.fl, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_special;
      vec_t v[$];
      exp_t e; int cyc; logic to, acc;
      v.push_back('{32'h7F800000, 32'h3F800000, 1'b1, 1'b0, 32'h7F800000, 4'b0000, 2});
      v.push_back('{32'h3F800000, 32'h7F800000, 1'b0, 1'b0, 32'hFF800000, 4'b0000, 2});
      v.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7F800000, 4'b0000, 2});
      v.push_back('{32'hFF800000, 32'hFF800000, 1'b0, 1'b0, 32'h7FC00000, 4'b1000, 2});
      v.push_back('{32'h7FC00001, 32'h3F800000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, 2});
      v.push_back('{32'h3F800000, 32'hFF800001, 1'b1, 1'b1, 32'h7FC00000, 4'b1000, 2});
      foreach (v[i]) begin
         send(v[i].a, v[i].b, v[i].add, v[i].rm, v[i].res, v[i].fl, v[i].lat, acc);
         wait_out(cyc, to);
         e = sb.pop_front();
         n_chk++;
         if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
            n_fail++;
            $display("FAIL special[%0d]: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                     i, result, flags, cyc, to, e.res, e.fl, e.lat);
         end
         drain();
      end
   endtask

   task automatic test_back_to_back;
      exp_t e; int cyc; logic to, acc;
      send(32'h7F800000, 32'hFF800000, 1'b1, 1'b0, 32'h7FC00000, 4'b1000, 2, acc);
      wait_out(cyc, to);
      e = sb.pop_front();
      n_chk++;
      if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
         n_fail++;
         $display("FAIL inf_minus_inf: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                  result, flags, cyc, to, e.res, e.fl, e.lat);
      end
      opa = 32'h12345678; opb = 32'h9ABCDEF0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         n_chk++;
         if (result !== e.res || flags !== e.fl || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: res=%h fl=%b ov=%b ir=%b, expected %h %b 1 0",
                     k, result, flags, out_valid, in_ready, e.res, e.fl);
         end
      end
      out_ready = 1'b1;
      send(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 4'b0000, 4, acc);
      out_ready = 1'b0;
      n_chk++;
      if (acc !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: ir=%b busy=%b ov=%b, expected 1 1 0", acc, busy, out_valid);
      end
      wait_out(cyc, to);
      e = sb.pop_front();
      n_chk++;
      if (to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
         n_fail++;
         $display("FAIL b2b_result: res=%h fl=%b lat=%0d to=%b, expected %h %b %0d",
                  result, flags, cyc, to, e.res, e.fl, e.lat);
      end
      drain();
   endtask

   task automatic test_reset_mid;
      exp_t e; int cyc; logic to, acc, seen;
      send(32'h3F800000, 32'h3F7FFFFF, 1'b0, 1'b0, 32'h33800000, 4'b0000, 10, acc);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      n_chk++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || result !== '0) begin
         n_fail++;
         $display("FAIL reset_abort: ov=%b busy=%b ir=%b res=%h, expected 0 0 0 0",
                  out_valid, busy, in_ready, result);
      end
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1 seen = seen | out_valid | busy;
      end
      n_chk++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_output: activity=%b, expected 0", seen);
      end
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      send(32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h40000000, 4'b0000, 4, acc);
      wait_out(cyc, to);
      e = sb.pop_front();
      n_chk++;
      if (acc !== 1'b1 || to || result !== e.res || flags !== e.fl || cyc !== e.lat) begin
         n_fail++;
         $display("FAIL reset_first_accept: acc=%b res=%h fl=%b lat=%0d to=%b, expected 1 %h %b %0d",
                  acc, result, flags, cyc, to, e.res, e.fl, e.lat);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_cancel();
      test_round();
      test_overflow();
      test_special();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fpu_add_param.md
FPU_ADD_PARAM -- requirements
Module: fpu_add_param

Interface
REQ-001 Parameter EXP_W, default 8, exponent width.
REQ-002 Parameter MAN_W, default 23, stored fraction width (hidden bit implicit).
REQ-003 Parameter NORM_STEP, default 4, maximum left-shift per normalization cycle; legal range 1..MAN_W+3.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operands and controls are valid.
REQ-007 in_ready  output  1  block can accept an operation.
REQ-008 opa, opb  input  EXP_W+MAN_W+1  IEEE-754-style operands {sign, exp, frac}.
REQ-009 is_addition  input  1  1 = opa+opb, 0 = opa-opb.
REQ-010 round_mode  input  1  0 = round-to-nearest-even, 1 = truncate toward zero.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 result  output  EXP_W+MAN_W+1  rounded sum.
REQ-014 flags  output  4  {invalid, overflow, underflow, inexact}.
REQ-015 busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ALIGN, NORM, ROUND and HOLD.
REQ-017 in_ready SHALL be high when the state is IDLE, or when it is HOLD and out_ready is high; it SHALL be low while rst is low.
REQ-018 On in_valid&in_ready: capture opa, opb, is_addition and round_mode, then go to ALIGN; captured values SHALL NOT change until the next acceptance.
REQ-019 Effective operation SHALL be addition when opa sign ^ opb sign ^ is_addition is 1, and subtraction otherwise.
REQ-020 ALIGN (1 cycle): order operands by magnitude {exp, frac}; right-shift the smaller significand by the exponent difference into a MAN_W+5-bit datapath {carry, hidden, frac, guard, round, sticky}; OR all shifted-out bits into sticky.
REQ-021 ALIGN add/sub: on carry-out, shift right 1 (preserving sticky) and increment exp; then go to NORM.
REQ-022 NORM, per cycle: if hidden bit=1, significand=0, or exp=1, go to ROUND with no shift; otherwise shift left by min(NORM_STEP, leading zeros, exp-1) and decrement exp by that amount.
REQ-023 NORM SHALL therefore occupy 1+ceil(lz/NORM_STEP) cycles; total latency from the acceptance edge to first out_valid = 4+ceil(lz/NORM_STEP) cycles.
REQ-024 ROUND (1 cycle): in RNE, increment when G&(R|S|LSB); in truncate, never increment.
REQ-025 ROUND: a rounding carry SHALL renormalize (exp+1); inexact = G|R|S; next state is HOLD.
REQ-026 Overflow (exp reaches all-ones): RNE gives ±inf; truncate gives ±max-finite; overflow=1 and inexact=1 in both modes.
REQ-027 Underflow: a result with exp=0 after normalization SHALL flush to signed zero with underflow=1 and inexact=1.
REQ-028 Inputs with exp=0 SHALL be treated as signed zero (flush-to-zero).
REQ-029 An exact zero difference SHALL give +0 in both modes; (-0)+(-0) SHALL give -0.
REQ-030 Special inputs SHALL go ALIGN->HOLD directly, for a latency of 2 cycles.
REQ-031 Any NaN, or inf-inf effective subtraction, SHALL give the canonical qNaN {0, all-ones, 1 followed by zeros} with invalid=1.
REQ-032 Otherwise, an inf operand SHALL pass through with its sign.
REQ-033 HOLD: result and flags SHALL remain stable while out_valid=1 and out_ready=0.
REQ-034 On out_ready=1 in HOLD: go to IDLE, or to ALIGN if a new operation is accepted in the same cycle (zero-bubble back-to-back).
REQ-035 result and flags SHALL only update on the ROUND->HOLD or ALIGN->HOLD transitions.

Reset
REQ-036 While rst=0, asynchronously: state=IDLE, out_valid=0, result=0, flags=0, busy=0, all datapath registers=0.
REQ-037 Reset asserted mid-operation SHALL abort the operation with no output; the first acceptance is possible in the first cycle after rst rises.

Verification (EXP_W=8, MAN_W=23, NORM_STEP=4)
REQ-038 3F800000+3F800000, RNE -> result 40000000, flags 0, out_valid 4 cycles after acceptance.
REQ-039 3F800000-3F7FFFFF (is_addition=0) -> result 33800000, flags 0, out_valid 10 cycles after acceptance.
REQ-040 3F800000+33800000, RNE -> 3F800000, inexact=1 (tie to even); 3F800000+33C00000, RNE -> 3F800001, inexact=1; same operands with truncate -> 3F800000 in both cases.
REQ-041 7F7FFFFF+7F7FFFFF -> RNE 7F800000, truncate 7F7FFFFF; flags overflow=1, inexact=1 in both.
REQ-042 7F800000+FF800000 -> 7FC00000, invalid=1, latency 2; then hold out_ready=0 for 5 cycles -> result stable, in_ready=0; then pulse out_ready together with a new in_valid -> accepted in the same cycle.
REQ-043 rst driven low during NORM of the REQ-039 case -> out_valid=0 and busy=0 immediately; no result after rst releases.
